seq_sub_div8: RTL and testbench

- Multi-cycle unsigned restoring divider built on a trial subtractor, one quotient bit per clock.
- It is the counterpart of the datapath's 8-bit adders: it recovers quotient and remainder through repeated subtraction instead of building sums.
- Sits beside the adder blocks in the lab datapath.
- A controller drives it with a start/done handshake.

---
 rtl/seq_sub_div8.sv | 107 ++++++++++
 tb/tb_seq_sub_div8.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seq_sub_div8.sv
// Multi-cycle unsigned restoring divider: one trial subtraction, one quotient bit per clock.
// A controller launches it with start and collects results on the one-cycle done pulse.
module seq_sub_div8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] d_q, v_q, r_q, q_q;
    logic [CW-1:0]    cnt_q;
    logic             dz_q;
    logic             busy_q, done_q, div_by_zero_q;
    logic [WIDTH-1:0] quotient_q, remainder_q;

    logic [WIDTH:0]   trial, diff;
    logic [WIDTH-1:0] r_d, q_d;

    // The top bit of the WIDTH+1 bit difference is the borrow, since R < V always holds.
    always_comb begin
        trial = {r_q, d_q[WIDTH-1]};
        diff  = trial - {1'b0, v_q};
        r_d   = diff[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], 1'b1};
        if (diff[WIDTH]) begin
            r_d = trial[WIDTH-1:0];
            q_d = {q_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            d_q           <= '0;
            v_q           <= '0;
            r_q           <= '0;
            q_q           <= '0;
            cnt_q         <= '0;
            dz_q          <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        d_q           <= dividend;
                        v_q           <= divisor;
                        cnt_q         <= '0;
                        busy_q        <= 1'b1;
                        div_by_zero_q <= 1'b0;
                        if (divisor == '0) begin
                            // Zero divisor skips the iterations; FIN publishes these directly.
                            r_q     <= dividend;
                            q_q     <= '1;
                            dz_q    <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            r_q     <= '0;
                            q_q     <= '0;
                            dz_q    <= 1'b0;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    d_q   <= {d_q[WIDTH-2:0], 1'b0};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) state_q <= FIN;
                end
                FIN: begin
                    quotient_q    <= q_q;
                    remainder_q   <= r_q;
                    div_by_zero_q <= dz_q;
                    done_q        <= 1'b1;
                    busy_q        <= 1'b0;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;
endmodule

// File: tb/tb_seq_sub_div8.sv
// Scoreboard bench for seq_sub_div8: driver pushes expected results, monitor checks each done.
module tb_seq_sub_div8;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0, divisor = '0;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient, remainder;

    seq_sub_div8 #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [7:0] a, b, q, r;
        logic       dz;
        int         done_cyc;
        int         busy_cycles;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: independent of the driver, compares whatever the DUT publishes.
    int         busy_run = 0;
    logic [7:0] last_q = '0, last_r = '0;
    always @(negedge clk) begin
        if (reset) begin
            busy_run = 0;
            last_q   = '0;
            last_r   = '0;
        end else begin
            if (busy && done) chk("busy_done_overlap", 1, 0);
            if (busy) begin
                busy_run++;
                chk("quotient_held", quotient, last_q);
                chk("remainder_held", remainder, last_r);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("busy_cycles", busy_run, e.busy_cycles);
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("div_by_zero", div_by_zero, e.dz);
                    if (e.b != 0) begin
                        chk("invariant", quotient * e.b + remainder, e.a);
                        chk("rem_lt_div", remainder < e.b, 1);
                    end
                end
                last_q   = quotient;
                last_r   = remainder;
                busy_run = 0;
            end
        end
    end

    // Reference: plain integer division; zero divisor yields all ones and the dividend.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int acc_cyc);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 0) begin
            e.q = 8'hFF; e.r = a; e.dz = 1'b1;
            e.done_cyc = acc_cyc + 1; e.busy_cycles = 1;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0;
            e.done_cyc = acc_cyc + 9; e.busy_cycles = 9;
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic launch(input logic [7:0] a, input logic [7:0] b, input bit accept);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (accept) exp_q.push_back(model(a, b, cyc));
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 40) begin @(negedge clk); n++; end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!done && n < 40) begin @(negedge clk); n++; end
        if (!done) chk("done_timeout", 1, 0);
    endtask

    initial begin
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dz", div_by_zero, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        launch(200, 7, 1);
        wait_idle();
        launch(255, 1, 1);   wait_idle();
        launch(5, 9, 1);     wait_idle();
        launch(255, 255, 1); wait_idle();
        launch(0, 13, 1);    wait_idle();
        launch(100, 0, 1);   wait_idle();
        launch(9, 3, 1);     wait_idle();

        // start during RUN is ignored; start in the done cycle is accepted
        launch(200, 7, 1);
        repeat (2) @(negedge clk);
        launch(50, 5, 0);
        wait_done();
        launch(50, 5, 1);
        wait_idle();

        // asynchronous reset on the 4th RUN cycle discards the operation
        launch(200, 7, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_quotient", quotient, 0);
        chk("mid_rst_remainder", remainder, 0);
        chk("mid_rst_dz", div_by_zero, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        launch(13, 4, 1);
        wait_idle();

        // random sweep, each launched in the previous done cycle
        launch(8'($urandom), 8'($urandom_range(1, 255)), 1);
        for (int i = 1; i < 2000; i++) begin
            wait_done();
            launch(8'($urandom), 8'($urandom_range(1, 255)), 1);
        end
        wait_idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
